mul_controller: RTL and testbench
=================================

# mul_controller

Sequencing FSM for the 8-bit repeated-addition multiplier datapath (`mul_datapath`). It accepts a start request and strobes the load, clear and decrement controls so the datapath computes P = A × B by adding A into P B times. It reports busy, done and watchdog-error status to the host, which drives the operands on the shared `data_in` bus when requested. It sits directly beside the datapath, with `eqz` as its only feedback.

## Interface
- `MAX_ITER`, default 255: watchdog limit on add iterations per multiply. It must be at least 1.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a multiply. Sampled only in IDLE.
- `abort` input, 1 bit: synchronous cancel.
- `eqz` input, 1 bit: from the datapath; 1 when the counter equals 0.
- `ldA` output, 1 bit: load register A from `data_in`.
- `ldB` output, 1 bit: load register B from `data_in`.
- `ldC` output, 1 bit: load the counter from `data_in`.
- `clearP` output, 1 bit: clear the product register.
- `ldP` output, 1 bit: P ← P + A.
- `dec` output, 1 bit: decrement the counter.
- `opa_req` output, 1 bit: host must present A on `data_in` this cycle.
- `opb_req` output, 1 bit: host must present B on `data_in` this cycle.
- `busy` output, 1 bit: multiply in progress.
- `done` output, 1 bit: one-cycle completion pulse; P is valid.
- `err` output, 1 bit: watchdog tripped. Held until `abort`.

## Operation
- States: IDLE, LOAD_A, LOAD_B, ADD, DONE, ERR.
- IDLE
  - All outputs are 0.
  - `start`=1 → LOAD_A.
- LOAD_A
  - Asserts `ldA` and `opa_req`; A is captured at the closing edge.
  - Always → LOAD_B.
- LOAD_B
  - Asserts `ldB`, `ldC`, `clearP` and `opb_req`; B goes into both the B register and the counter, and P is zeroed.
  - Clears the iteration counter `iter`.
  - Always → ADD.
- ADD (Mealy outputs)
  - If `eqz`=1: no strobes; → DONE.
  - Else if `iter`==`MAX_ITER`: no strobes; → ERR.
  - Else: `ldP`=`dec`=1 and `iter`++; stay in ADD.
- DONE
  - `done`=1 for exactly one cycle.
  - → IDLE. `start` in this cycle is ignored.
- ERR
  - `err`=1 and no strobes.
  - Stays in ERR until `abort`; `start` is ignored.
- `busy`=1 in LOAD_A, LOAD_B and ADD; 0 otherwise.
- `abort` priority:
  - In LOAD_A, LOAD_B, ADD or ERR, `abort` forces the next state to IDLE.
  - In the abort cycle all datapath strobes are suppressed, even in ADD.
  - `abort` is ignored in IDLE and DONE.
  - P is not cleared by abort; its contents are undefined to the host.
- `start` while not in IDLE has no effect and is not queued.
- `iter` width is clog2(`MAX_ITER`+1) and it saturates at `MAX_ITER`. With the default, the watchdog never fires for legal 8-bit B, since `eqz` is checked first.
- B=0: ADD is entered with `eqz`=1, so there are zero adds and P=0.

## Timing
- Reset (asynchronous assert): state=IDLE, `iter`=0, and every output is 0 immediately. Release is synchronous to `clk`.
- Reset mid-operation: return to IDLE with no `done` pulse. The host must restart.
- Latency: `start` sampled at the edge ending cycle 0 gives LOAD_A in cycle 1, LOAD_B in cycle 2, and ADD from cycle 3 through cycle 3+B. DONE is in cycle 4+B.
- Total latency is 4+B cycles from the `start` cycle, with B add cycles.
- Operand rule: `data_in` must be stable and valid throughout every cycle in which `opa_req` or `opb_req` is high.
- `ldP`/`dec` depend combinationally on `eqz`, `abort` and state. All other outputs decode from state only.
- Back-to-back: the earliest next `start` is the cycle after DONE, i.e. IDLE.

## Structure
- Package `mul_pkg` holds:
  - the state enum typedef (`mul_state_t`, binary encoding, IDLE=0);
  - the default `MAX_ITER` constant;
  - the `iter` width function.
- The natural sub-module is `mul_watchdog`: the clearable, saturating iteration counter with an `at_limit` output.
- The FSM (state register plus next-state/output decode) stays in `mul_controller`.
- The bench instantiates `mul_controller` together with `mul_datapath`, and observes P through hierarchy.

## Test plan
- A=3, B=5, `start` in cycle 0:
  - `opa_req` in cycle 1 and `opb_req` in cycle 2;
  - five cycles with `ldP`;
  - `done` in cycle 9 with P=15 and `busy` low.
- A=7, B=0: zero `ldP` cycles, `done` in cycle 4, P=0. Then A=0, B=7: `done` in cycle 11, P=0.
- `MAX_ITER`=3, A=2, B=5:
  - three `ldP` cycles, then ERR with `err`=1 held for 10 cycles;
  - `start` is ignored in ERR;
  - `abort` returns to IDLE and `err`=0.
- A=4, B=6, `abort` in the second ADD cycle: no strobes in that cycle, IDLE next, and `done` never pulses.
- `rst_n` low in the middle of ADD:
  - outputs go to 0 asynchronously before the next edge;
  - after release, A=255, B=255 completes with P=65025 and `done` in cycle 259.
- `start` held high continuously: `start` pulses during `busy` are ignored, a new multiply begins in the cycle after each DONE, and every result is correct.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier controller.
//   mul_state_t      : controller state encoding (binary, IDLE = 0)
//   MAX_ITER_DEFAULT : default watchdog limit on add iterations
//   iter_width()     : width of the iteration counter for a given limit
package mul_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_ADD    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } mul_state_t;

    localparam int MAX_ITER_DEFAULT = 255;

    // Enough bits to hold 0..max_iter inclusive.
    function automatic int iter_width(input int max_iter);
        return (max_iter < 1) ? 1 : $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/mul_datapath.sv
// 8-bit repeated-addition multiplier datapath: operand registers A and B,
// down-counter C and 16-bit product P (P <- P + A on each ldP).
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   data_in             : shared operand bus from the host
//   ldA, ldB, ldC       : load A / B / counter from data_in
//   clearP, ldP, dec    : clear P / accumulate A into P / decrement counter
//   eqz                 : counter equals zero
//   a, b, p             : register contents
module mul_datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        ldA,
    input  logic        ldB,
    input  logic        ldC,
    input  logic        clearP,
    input  logic        ldP,
    input  logic        dec,
    output logic        eqz,
    output logic [7:0]  a,
    output logic [7:0]  b,
    output logic [15:0] p
);

    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [7:0]  c_reg;
    logic [15:0] p_reg;

    assign eqz = (c_reg == 8'd0);
    assign a   = a_reg;
    assign b   = b_reg;
    assign p   = p_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
            p_reg <= '0;
        end else begin
            if (ldA) a_reg <= data_in;
            if (ldB) b_reg <= data_in;
            if (ldC) begin
                c_reg <= data_in;
            end else if (dec) begin
                c_reg <= c_reg - 8'd1;
            end
            if (clearP) begin
                p_reg <= '0;
            end else if (ldP) begin
                p_reg <= p_reg + {8'd0, a_reg};
            end
        end
    end

endmodule

// File: rtl/mul_watchdog.sv
// Clearable, saturating iteration counter for the multiply watchdog.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous clear to 0 (has priority over inc)
//   inc        : count one add iteration
//   at_limit   : counter has reached MAX_ITER
module mul_watchdog
    import mul_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam int ITER_W = iter_width(MAX_ITER);

    logic [ITER_W-1:0] iter_reg;

    assign at_limit = (iter_reg == ITER_W'(MAX_ITER));

    // Saturates at MAX_ITER so it can never wrap back below the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_reg <= '0;
        end else if (clear) begin
            iter_reg <= '0;
        end else if (inc && !at_limit) begin
            iter_reg <= iter_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mul_controller.sv
// Sequencing FSM for the repeated-addition multiplier datapath.
// Loads A, then B into both the B register and the counter while clearing P,
// then adds A into P once per counter decrement until eqz. A watchdog stops
// the add loop after MAX_ITER iterations and parks the FSM in ERR.
// Ports:
//   clk, rst_n                 : clock and asynchronous active-low reset
//   start, abort               : host request / synchronous cancel
//   eqz                        : datapath counter-is-zero feedback
//   ldA, ldB, ldC, clearP      : datapath load/clear strobes
//   ldP, dec                   : add-iteration strobes (Mealy on eqz/abort)
//   opa_req, opb_req           : host must drive A / B on data_in this cycle
//   busy, done, err            : status to host
module mul_controller
    import mul_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic eqz,
    output logic ldA,
    output logic ldB,
    output logic ldC,
    output logic clearP,
    output logic ldP,
    output logic dec,
    output logic opa_req,
    output logic opb_req,
    output logic busy,
    output logic done,
    output logic err
);

    mul_state_t state_reg;
    mul_state_t state_next;
    logic       add_en;
    logic       clr_iter;
    logic       at_limit;

    mul_watchdog #(
        .MAX_ITER (MAX_ITER)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clr_iter),
        .inc      (add_en),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus the Mealy add strobe. eqz is tested before the
    // watchdog so a legal count never trips it, and abort beats both.
    always_comb begin
        state_next = state_reg;
        add_en     = 1'b0;
        clr_iter   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                state_next = abort ? S_IDLE : S_LOAD_B;
            end
            S_LOAD_B: begin
                clr_iter   = 1'b1;
                state_next = abort ? S_IDLE : S_ADD;
            end
            S_ADD: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (eqz) begin
                    state_next = S_DONE;
                end else if (at_limit) begin
                    state_next = S_ERR;
                end else begin
                    add_en = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            S_ERR: begin
                if (abort) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath strobes are masked by abort so a cancelled cycle never
    // disturbs the registers; status outputs decode from state alone.
    assign ldA     = (state_reg == S_LOAD_A) && !abort;
    assign ldB     = (state_reg == S_LOAD_B) && !abort;
    assign ldC     = (state_reg == S_LOAD_B) && !abort;
    assign clearP  = (state_reg == S_LOAD_B) && !abort;
    assign ldP     = add_en;
    assign dec     = add_en;
    assign opa_req = (state_reg == S_LOAD_A);
    assign opb_req = (state_reg == S_LOAD_B);
    assign busy    = (state_reg == S_LOAD_A) || (state_reg == S_LOAD_B) ||
                     (state_reg == S_ADD);
    assign done    = (state_reg == S_DONE);
    assign err     = (state_reg == S_ERR);

endmodule

// File: tb/tb_mul_controller.sv
// Scoreboard bench: controller + datapath with the default watchdog, plus a
// second pair with MAX_ITER=3 for the watchdog path.
module tb_mul_controller;

    typedef struct {
        int p;
        int b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main instance ----------------
    logic        start = 1'b0, abort = 1'b0;
    logic        eqz, ldA, ldB, ldC, clearP, ldP, dec;
    logic        opa_req, opb_req, busy, done, err;
    logic [7:0]  data_in, a_q, b_q;
    logic [15:0] p_q;

    logic [7:0]  op_a_arr [0:63];
    logic [7:0]  op_b_arr [0:63];
    logic [5:0]  op_wr = '0, op_rd = '0;

    assign data_in = opa_req ? op_a_arr[op_rd] : (opb_req ? op_b_arr[op_rd] : 8'd0);

    mul_controller u_ctl (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eqz(eqz),
        .ldA(ldA), .ldB(ldB), .ldC(ldC), .clearP(clearP), .ldP(ldP), .dec(dec),
        .opa_req(opa_req), .opb_req(opb_req), .busy(busy), .done(done), .err(err)
    );

    mul_datapath u_dp (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .ldA(ldA), .ldB(ldB),
        .ldC(ldC), .clearP(clearP), .ldP(ldP), .dec(dec), .eqz(eqz),
        .a(a_q), .b(b_q), .p(p_q)
    );

    // ---------------- watchdog instance (MAX_ITER = 3) ----------------
    logic        start3 = 1'b0, abort3 = 1'b0;
    logic        eqz3, ldA3, ldB3, ldC3, clearP3, ldP3, dec3;
    logic        opa_req3, opb_req3, busy3, done3, err3;
    logic [7:0]  data_in3, a3_q, b3_q;
    logic [15:0] p3_q;

    assign data_in3 = opa_req3 ? 8'd2 : (opb_req3 ? 8'd5 : 8'd0);

    mul_controller #(.MAX_ITER(3)) u_ctl3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .eqz(eqz3),
        .ldA(ldA3), .ldB(ldB3), .ldC(ldC3), .clearP(clearP3), .ldP(ldP3), .dec(dec3),
        .opa_req(opa_req3), .opb_req(opb_req3), .busy(busy3), .done(done3), .err(err3)
    );

    mul_datapath u_dp3 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in3), .ldA(ldA3), .ldB(ldB3),
        .ldC(ldC3), .clearP(clearP3), .ldP(ldP3), .dec(dec3), .eqz(eqz3),
        .a(a3_q), .b(b3_q), .p(p3_q)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    exp_t exp_q[$];
    int   opa_cyc = 0;
    int   ldp_cnt = 0;
    bit   pop_pending = 1'b0;

    // Monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pop_pending) begin
                op_rd = op_rd + 6'd1;
                pop_pending = 1'b0;
            end
            if (opa_req) begin
                opa_cyc = cyc;
                ldp_cnt = 0;
            end
            if (opb_req) begin
                check("opb_after_opa", cyc - opa_cyc, 1);
                pop_pending = 1'b1;
            end
            if (ldP) ldp_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_expected", 0, 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("product", int'(p_q), e.p);
                    check("latency_opa_to_done", cyc - opa_cyc, 3 + e.b);
                    check("ldp_cycles", ldp_cnt, e.b);
                    check("busy_at_done", int'(busy), 0);
                    $display("txn: A*B=%0d latency=%0d adds=%0d", p_q, cyc - opa_cyc + 1, ldp_cnt);
                end
            end
        end
    end

    task automatic push_op(input int a, input int b, input bit expect_done);
        op_a_arr[op_wr] = 8'(a);
        op_b_arr[op_wr] = 8'(b);
        op_wr = op_wr + 6'd1;
        if (expect_done) exp_q.push_back('{a * b, b});
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic run_mul(input int a, input int b);
        push_op(a, b, 1'b1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("opa_req_cycle1", int'(opa_req), 1);
        wait_drain(600);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_ldA", int'(ldA), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Main function
        run_mul(3, 5);
        run_mul(7, 0);
        run_mul(0, 7);
        run_mul(255, 1);

        // Abort in the second ADD cycle of A=4, B=6
        push_op(4, 6, 1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("abort_first_add_ldP", int'(ldP), 1);
        @(posedge clk); #1 abort = 1'b1;
        #1;
        check("abort_ldP_masked", int'(ldP), 0);
        check("abort_dec_masked", int'(dec), 0);
        @(posedge clk); #1 abort = 1'b0;
        check("abort_to_idle_busy", int'(busy), 0);
        repeat (12) @(posedge clk);
        #1 check("abort_no_done_pending", exp_q.size(), 0);

        // Asynchronous reset in the middle of ADD
        push_op(9, 9, 1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("pre_reset_ldP", int'(ldP), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_ldP", int'(ldP), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_dec", int'(dec), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_mul(255, 255);

        // Watchdog: MAX_ITER=3 with B=5
        begin
            int cnt = 0;
            int k = 0;
            @(posedge clk); #1 start3 = 1'b1;
            @(posedge clk); #1 start3 = 1'b0;
            while (!err3 && k < 40) begin
                @(negedge clk);
                if (ldP3) cnt++;
                k++;
            end
            check("wdog_err_reached", int'(err3), 1);
            check("wdog_ldp_cycles", cnt, 3);
            check("wdog_product", int'(p3_q), 6);
            start3 = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("wdog_err_held", int'(err3), 1);
            end
            check("wdog_busy_in_err", int'(busy3), 0);
            @(posedge clk); #1 start3 = 1'b0; abort3 = 1'b1;
            @(posedge clk); #1 abort3 = 1'b0;
            check("wdog_err_cleared", int'(err3), 0);
            check("wdog_idle_busy", int'(busy3), 0);
            $display("txn: watchdog tripped after %0d adds, cleared by abort", cnt);
        end

        // start held high: back-to-back multiplies
        begin
            for (int i = 0; i < 4; i++) begin
                push_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 20)), 1'b1);
            end
            @(posedge clk); #1 start = 1'b1;
            wait_drain(400);
            start = 1'b0;
            repeat (3) @(posedge clk);
            #1 check("held_start_idle", int'(busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
